// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone classic arbiter with a per-transfer wait timeout.
// Optional round-robin tie-break when WB_ARB_ROUND_ROBIN_EN is defined; fixed priority (m1 wins) otherwise.
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                    s_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_M0,
        GRANT_M1
    } state_e;

    typedef enum logic {
        M0,
        M1
    } master_e;

    state_e           state_q, state_d;
    master_e          last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic own_cyc;
    logic own_stb;
    logic timeout_hit;

    // A strobe without cyc is not a request, so it never counts as a wait.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        own_cyc = 1'b0;
        own_stb = 1'b0;
        unique case (state_q)
            GRANT_M0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_cyc_i & m0_stb_i;
            end
            GRANT_M1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_cyc_i & m1_stb_i;
            end
            default: ;
        endcase
    end

    assign timeout_hit = TIMEOUT_EN && own_stb && !s_ack_i && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    if (last_grant_q == M0) begin
                        state_d      = GRANT_M1;
                        last_grant_d = M1;
                    end else begin
                        state_d      = GRANT_M0;
                        last_grant_d = M0;
                    end
`else
                    state_d      = GRANT_M1;
                    last_grant_d = M1;
`endif
                end else if (m1_cyc_i) begin
                    state_d      = GRANT_M1;
                    last_grant_d = M1;
                end else if (m0_cyc_i) begin
                    state_d      = GRANT_M0;
                    last_grant_d = M0;
                end
            end
            GRANT_M0, GRANT_M1: begin
                // An ack always beats a coincident timeout; the hit term already excludes it.
                if (!own_cyc || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (s_ack_i) begin
                    cnt_d = '0;
                end else if (own_stb && TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            state_q      <= IDLE;
            last_grant_q <= M0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Slave and master-return muxes; only the current owner sees ack, err and read data.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        unique case (state_q)
            GRANT_M0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i & m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m0_err_o = timeout_hit;
            end
            GRANT_M1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i & m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                m1_err_o = timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Lets the CPU's instruction-fetch master (m0) and data-memory master (m1) share a single SRAM/bus slave port.
- Grants one master per bus cycle and holds the grant until that master drops cyc.
- Routes ack and read data back to the owner only, and aborts a stuck transfer with a timeout error pulse.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, wait cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  IF master request
- m0_adr_i  input  ADDR_WIDTH  IF address
- m0_dat_i  input  DATA_WIDTH  IF write data
- m0_sel_i  input  DATA_WIDTH/8  IF byte select
- m0_ack_o, m0_err_o  output  1 each  IF ack / timeout error
- m0_dat_o  output  DATA_WIDTH  IF read data
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i, m1_ack_o, m1_err_o, m1_dat_o: same widths and directions as m0, for the MEM master
- s_cyc_o, s_stb_o, s_we_o  output  1 each  slave request
- s_adr_o  output  ADDR_WIDTH  slave address
- s_dat_o  output  DATA_WIDTH  slave write data
- s_sel_o  output  DATA_WIDTH/8  slave byte select
- s_ack_i  input  1  slave ack
- s_dat_i  input  DATA_WIDTH  slave read data

Behaviour:
- FSM states: IDLE, GRANT_M0, GRANT_M1. State, last_grant and the wait counter are registered. All outputs are combinational from state and inputs.
- Reset (reset==0 at a clk edge):
  - state=IDLE, last_grant=M0, counter=0.
  - Every s_* output is 0 and every m*_ack_o/m*_err_o/m*_dat_o is 0 while in IDLE.
- IDLE transitions:
  - Only m0_cyc_i=1 -> GRANT_M0.
  - Only m1_cyc_i=1 -> GRANT_M1.
  - Both=1 -> GRANT_M1 (fixed priority: data beats fetch).
  - Neither -> stay IDLE.
- Arbitration latency is one cycle: a request seen in IDLE reaches the slave on the next cycle.
- GRANT_Mx routing:
  - s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i; adr, dat, sel and we are passed through from mx.
  - mx_ack_o=s_ack_i, mx_dat_o=s_dat_i.
  - The non-owner sees ack=0, err=0, dat=0.
- Grant hold:
  - The grant persists while mx_cyc_i=1, including across multiple stb/ack beats.
  - The owner dropping cyc -> IDLE on the next edge. There is always one IDLE cycle between owners, even with the other master waiting.
  - last_grant is updated on every IDLE->GRANT transition.
- Timeout counter (TIMEOUT_CYCLES>0):
  - Width is $clog2(TIMEOUT_CYCLES+1). Cleared on entry to GRANT and on any cycle with s_ack_i=1.
  - Increments each GRANT cycle with mx_stb_i=1 and s_ack_i=0.
  - When counter==TIMEOUT_CYCLES-1 and s_ack_i=0: mx_err_o=1 for that single cycle, state->IDLE next edge, and s_cyc_o/s_stb_o drop.
  - The master must drop cyc after err. If it keeps cyc=1, it is re-granted from IDLE under normal arbitration.
- Simultaneous events:
  - ack in the same cycle as a timeout hit: ack wins, no err, counter cleared.
  - Owner drops cyc in the same cycle as ack: ack is still forwarded, then IDLE.
- Reset mid-transfer: state->IDLE on that edge, the slave request drops, any late s_ack_i is ignored (no m*_ack_o in IDLE).
- mx_stb_i without mx_cyc_i is ignored.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: when both cyc are asserted in IDLE, grant goes to the master that is not last_grant (after reset, m1 wins the first tie since last_grant=M0). Alternates on back-to-back contention.
- Undefined: fixed priority, m1 always wins ties, and last_grant is unused apart from its reset value.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Single read: m0 cyc/stb=1, adr=0x8000_0000 held; slave acks 2 cycles after s_stb_o with dat=0x0000_0013 -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0x13 in the ack cycle; m1_ack_o stays 0.
- Contention: m0 and m1 cyc rise in the same cycle; m1 writes 0xDEAD_BEEF to 0x8040_0000, sel=0xF -> slave sees m1 first with s_we_o=1. After m1 drops cyc: 1 IDLE cycle, then m0 is granted.
- Grant hold: m0 does 3 stb/ack beats without dropping cyc while m1 requests throughout -> m1 is not granted until 1 cycle after m0_cyc_i falls.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> m0_err_o=1 exactly on the 4th stb-wait cycle, s_cyc_o=0 the next cycle. Ack arriving on that 4th cycle instead -> no err.
- Reset mid-transfer: reset=0 while GRANT_M1 with stb pending, slave acks one cycle later -> all s_* outputs 0 the cycle after the reset edge; m1_ack_o stays 0.
- With WB_ARB_ROUND_ROBIN_EN: both masters issue continuous single-beat requests -> grant order m1, m0, m1, m0.
